// File: rtl/sa_cache_ctrl.sv
// N-way set-associative write-back, write-allocate cache controller.
// Optional build macro CACHE_STATS_EN adds hit/miss/writeback counters.
module sa_cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int INDEX_W = 10,
  parameter int WAYS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              hit,
  output logic              stall,
  output logic              mem_rd_en,
  output logic              mem_wd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_valid,
  input  logic              mem_wd_valid
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wbacks
`endif
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  ptr_q   [SETS];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic               req_wr;
  logic [DATA_W-1:0]  req_wdata;
  logic [WAY_W-1:0]   vic_q;

  logic               hit_any;
  logic [WAY_W-1:0]   hit_way;
  logic               inv_any;
  logic [WAY_W-1:0]   inv_way;
  logic [WAY_W-1:0]   vic_way;
  logic               vic_dirty;

  logic               wr_hit;
  logic               fill_done;
  logic               ram_we;
  logic [WAY_W-1:0]   ram_way;
  logic [DATA_W-1:0]  ram_wdata;

  if (OFF_W > 0) begin : g_off
    logic unused_off;
    assign unused_off = ^addr[OFF_W-1:0];
  end

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0]   t,
    input logic [INDEX_W-1:0] i
  );
    line_addr = ADDR_W'({t, i}) << OFF_W;
  endfunction

  // First matching way wins; first invalid way is the preferred victim.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && !hit_any &&
          tag_q[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w] && !inv_any) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    vic_way   = inv_any ? inv_way : ptr_q[req_idx];
    vic_dirty = valid_q[req_idx][vic_way] &
                dirty_q[req_idx][vic_way];
  end

  assign wr_hit    = (state_q == COMPARE) & hit_any & req_wr;
  assign fill_done = (state_q == FILL) & mem_data_valid;
  assign ram_we    = wr_hit | fill_done;
  assign ram_way   = fill_done ? vic_q : hit_way;
  assign ram_wdata = req_wr ? req_wdata : mem_data;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hit       = 1'b0;
    mem_rd_en = 1'b0;
    mem_wd_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_en || wr_en) state_d = COMPARE;
      end
      COMPARE: begin
        hit = hit_any;
        if (hit_any)        state_d = IDLE;
        else if (vic_dirty) state_d = WRITEBACK;
        else                state_d = FILL;
      end
      WRITEBACK: begin
        mem_wd_en = 1'b1;
        if (mem_wd_valid) state_d = FILL;
      end
      FILL: begin
        mem_rd_en = 1'b1;
        if (mem_data_valid) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall = (state_q != IDLE);

  // Data and tags carry no reset so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (ram_we)
      data_q[req_idx][ram_way] <= ram_wdata;
    if (fill_done)
      tag_q[req_idx][vic_q] <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      req_tag     <= '0;
      req_idx     <= '0;
      req_wr      <= 1'b0;
      req_wdata   <= '0;
      vic_q       <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      mem_addr    <= '0;
      mem_wd_data <= '0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rd_en || wr_en) begin
            req_tag   <= addr[ADDR_W-1 -: TAG_W];
            req_idx   <= addr[OFF_W +: INDEX_W];
            req_wr    <= wr_en;
            req_wdata <= wr_data;
          end
        end
        COMPARE: begin
          if (hit_any) begin
            if (req_wr) begin
              dirty_q[req_idx][hit_way] <= 1'b1;
            end else begin
              rd_data  <= data_q[req_idx][hit_way];
              rd_valid <= 1'b1;
            end
          end else begin
            vic_q <= vic_way;
            if (!inv_any && WAYS > 1)
              ptr_q[req_idx] <= ptr_q[req_idx] + 1'b1;
            if (vic_dirty) begin
              mem_addr <= line_addr(
                tag_q[req_idx][vic_way], req_idx);
              mem_wd_data <= data_q[req_idx][vic_way];
            end else begin
              mem_addr <= line_addr(req_tag, req_idx);
            end
          end
        end
        WRITEBACK: begin
          if (mem_wd_valid)
            mem_addr <= line_addr(req_tag, req_idx);
        end
        FILL: begin
          if (mem_data_valid) begin
            valid_q[req_idx][vic_q] <= 1'b1;
            dirty_q[req_idx][vic_q] <= req_wr;
            if (!req_wr) begin
              rd_data  <= mem_data;
              rd_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbacks <= '0;
    end else begin
      if (state_q == COMPARE && hit_any &&
          stat_hits != '1)
        stat_hits <= stat_hits + 1'b1;
      if (state_q == COMPARE && !hit_any &&
          stat_misses != '1)
        stat_misses <= stat_misses + 1'b1;
      if (state_q == WRITEBACK && mem_wd_valid &&
          stat_wbacks != '1)
        stat_wbacks <= stat_wbacks + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Randomised bench for sa_cache_ctrl against a line-level cache model.
// Defining CACHE_STATS_EN also checks the statistics counters.
module tb_sa_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr;
  logic [63:0] wr_data, rd_data;
  logic        rd_valid, hit, stall;
  logic        mem_rd_en, mem_wd_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_wd_data, mem_data;
  logic        mem_data_valid, mem_wd_valid;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_wbacks;
`endif

  int n_vec = 0;
  int n_bad = 0;

  sa_cache_ctrl #(
    .ADDR_W(32), .DATA_W(64), .INDEX_W(10), .WAYS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .hit(hit), .stall(stall),
    .mem_rd_en(mem_rd_en), .mem_wd_en(mem_wd_en),
    .mem_addr(mem_addr), .mem_wd_data(mem_wd_data),
    .mem_data(mem_data),
    .mem_data_valid(mem_data_valid),
    .mem_wd_valid(mem_wd_valid)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits(stat_hits),
    .stat_misses(stat_misses),
    .stat_wbacks(stat_wbacks)
`endif
  );

  always #5 clk = ~clk;

  // Model: cache contents per set/way, backing memory and the
  // architecturally latest value of every line.
  bit          m_valid [1024][2];
  bit          m_dirty [1024][2];
  logic [18:0] m_tag   [1024][2];
  int          m_ptr   [1024];
  logic [63:0] mem_q   [logic [31:0]];
  logic [63:0] gold_q  [logic [31:0]];
  int          e_hits, e_misses, e_wbacks;

  logic [63:0] last_rd;
  logic [31:0] last_wb_addr;
  logic [63:0] last_wb_data;
  logic        last_hit;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    if (mem_q.exists(a)) return mem_q[a];
    return {a ^ 32'hdead_beef, ~a};
  endfunction

  function automatic logic [63:0] gold_rd(input logic [31:0] a);
    if (gold_q.exists(a)) return gold_q[a];
    return mem_rd(a);
  endfunction

  // After reset every cached line is lost, so memory is the truth.
  task automatic reset_model();
    foreach (m_valid[s, w]) begin
      m_valid[s][w] = 1'b0;
      m_dirty[s][w] = 1'b0;
    end
    foreach (m_ptr[s]) m_ptr[s] = 0;
    gold_q.delete();
    e_hits = 0;
    e_misses = 0;
    e_wbacks = 0;
  endtask

  task automatic noise();
    rd_en   = 1'($urandom);
    wr_en   = 1'($urandom);
    addr    = $urandom;
    wr_data = {$urandom, $urandom};
  endtask

  task automatic quiet();
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic do_req(input bit w,
                        input logic [31:0] a,
                        input logic [63:0] d,
                        input bit abort);
    logic [31:0] la, wb_a, fill_a;
    logic [18:0] tg;
    logic [63:0] exp_rd;
    int set, vic, hw, dl;
    bit exp_hit, exp_wb;
    la  = a & ~32'h7;
    set = int'(la[12:3]);
    tg  = la[31:13];
    exp_hit = 1'b0;
    hw = 0;
    for (int k = 0; k < 2; k++)
      if (m_valid[set][k] && m_tag[set][k] == tg) begin
        exp_hit = 1'b1;
        hw = k;
      end
    exp_rd = gold_rd(la);
    exp_wb = 1'b0;
    vic = -1;
    wb_a = '0;
    if (!exp_hit) begin
      for (int k = 0; k < 2; k++)
        if (!m_valid[set][k] && vic < 0) vic = k;
      if (vic < 0) begin
        vic = m_ptr[set];
        m_ptr[set] = (vic + 1) % 2;
      end
      exp_wb = m_valid[set][vic] && m_dirty[set][vic];
      wb_a = {m_tag[set][vic], la[12:3], 3'b000};
    end
    fill_a = la;

    chk("idle_stall", stall, 1'b0);
    rd_en   = w ? 1'($urandom) : 1'b1;
    wr_en   = w;
    addr    = a;
    wr_data = d;
    @(negedge clk);
    noise();
    last_hit = hit;
    chk("cmp_stall", stall, 1'b1);
    chk("cmp_hit", hit, exp_hit);
    chk("cmp_mem_rd", mem_rd_en, 1'b0);
    chk("cmp_mem_wd", mem_wd_en, 1'b0);

    if (exp_hit) begin
      @(negedge clk);
      quiet();
      chk("hit_rd_valid", rd_valid, !w);
      if (!w) begin
        chk("hit_rd_data", rd_data, exp_rd);
        last_rd = rd_data;
      end
      chk("hit_stall", stall, 1'b0);
      chk("hit_pulse", hit, 1'b0);
      e_hits++;
      if (w) begin
        m_dirty[set][hw] = 1'b1;
        gold_q[la] = d;
      end
      return;
    end

    e_misses++;
    @(negedge clk);
    if (exp_wb) begin
      dl = $urandom_range(0, 3);
      for (int k = 0; k <= dl; k++) begin
        chk("wb_en", mem_wd_en, 1'b1);
        chk("wb_rd_en", mem_rd_en, 1'b0);
        chk("wb_addr", mem_addr, wb_a);
        chk("wb_data", mem_wd_data, gold_rd(wb_a));
        last_wb_addr = mem_addr;
        last_wb_data = mem_wd_data;
        if (k == dl) begin
          mem_data_valid = 1'b0;
          mem_wd_valid   = 1'b1;
        end else begin
          mem_data_valid = 1'($urandom);
        end
        noise();
        @(negedge clk);
      end
      mem_wd_valid = 1'b0;
      mem_q[wb_a] = gold_rd(wb_a);
      e_wbacks++;
    end else begin
      chk("no_wb", mem_wd_en, 1'b0);
    end

    if (abort) begin
      chk("abort_fill", mem_rd_en, 1'b1);
      quiet();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_stall", stall, 1'b0);
      chk("rst_mem_rd", mem_rd_en, 1'b0);
      chk("rst_mem_wd", mem_wd_en, 1'b0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      reset_model();
      return;
    end

    dl = $urandom_range(0, 3);
    for (int k = 0; k <= dl; k++) begin
      chk("fill_en", mem_rd_en, 1'b1);
      chk("fill_wd_en", mem_wd_en, 1'b0);
      chk("fill_addr", mem_addr, fill_a);
      chk("fill_rd_valid", rd_valid, 1'b0);
      if (k == dl) begin
        mem_wd_valid   = 1'b0;
        mem_data       = mem_rd(fill_a);
        mem_data_valid = 1'b1;
      end else begin
        mem_wd_valid = 1'($urandom);
        mem_data     = {$urandom, $urandom};
      end
      noise();
      @(negedge clk);
    end
    mem_data_valid = 1'b0;
    mem_wd_valid   = 1'b0;
    mem_data       = {$urandom, $urandom};
    quiet();
    chk("resp_stall", stall, 1'b1);
    chk("resp_rd_valid", rd_valid, !w);
    if (!w) begin
      chk("resp_rd_data", rd_data, exp_rd);
      last_rd = rd_data;
    end
    @(negedge clk);
    chk("post_rd_valid", rd_valid, 1'b0);
    m_valid[set][vic] = 1'b1;
    m_dirty[set][vic] = w;
    m_tag[set][vic]   = tg;
    if (w) gold_q[la] = d;
  endtask

  initial begin
    logic [31:0] ra;
    logic [9:0]  sets [3];
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr = '0;
    wr_data = '0;
    mem_data = '0;
    mem_data_valid = 1'b0;
    mem_wd_valid = 1'b0;
    last_rd = '0;
    last_wb_addr = '0;
    last_wb_data = '0;
    last_hit = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_hit", hit, 1'b0);
    chk("reset_mem_rd", mem_rd_en, 1'b0);
    chk("reset_mem_wd", mem_wd_en, 1'b0);
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_wd_data", mem_wd_data, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    mem_q[32'h1000] = 64'hAAAA_AAAA_AAAA_AAAA;
    do_req(1'b0, 32'h1000, '0, 1'b0);
    chk("t1_hit", last_hit, 1'b0);
    chk("t1_data", last_rd, 64'hAAAA_AAAA_AAAA_AAAA);
    do_req(1'b0, 32'h1000, '0, 1'b0);
    chk("t2_hit", last_hit, 1'b1);
    do_req(1'b1, 32'h3000, 64'h1234_5678_9ABC_DEF0, 1'b0);
    do_req(1'b0, 32'h3000, '0, 1'b0);
    chk("t3_hit", last_hit, 1'b1);
    chk("t3_data", last_rd, 64'h1234_5678_9ABC_DEF0);
    do_req(1'b0, 32'h5000, '0, 1'b0);
    do_req(1'b0, 32'h1000, '0, 1'b0);
    chk("t4_wb_addr", last_wb_addr, 32'h3000);
    chk("t4_wb_data", last_wb_data, 64'h1234_5678_9ABC_DEF0);
    chk("t4_data", last_rd, 64'hAAAA_AAAA_AAAA_AAAA);
`ifdef CACHE_STATS_EN
    chk("stat_hits", stat_hits, 32'd2);
    chk("stat_misses", stat_misses, 32'd4);
    chk("stat_wbacks", stat_wbacks, 32'd1);
`endif
    do_req(1'b0, 32'h9000, '0, 1'b1);
    do_req(1'b0, 32'h1000, '0, 1'b0);
    chk("t5_miss", last_hit, 1'b0);

    sets[0] = 10'h200;
    sets[1] = 10'h201;
    sets[2] = 10'h005;
    for (int i = 0; i < 300; i++) begin
      ra = {19'($urandom_range(0, 3)),
            sets[$urandom_range(0, 2)],
            3'($urandom)};
      do_req(1'($urandom), ra, {$urandom, $urandom},
             ($urandom_range(0, 39) == 0));
    end
`ifdef CACHE_STATS_EN
    chk("stat_hits_end", stat_hits, 32'(e_hits));
    chk("stat_misses_end", stat_misses, 32'(e_misses));
    chk("stat_wbacks_end", stat_wbacks, 32'(e_wbacks));
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
